fsx_compositor: RTL
===================

FSX_COMPOSITOR -- requirements
Module: fsx_compositor

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning vertical geometry in lines.
REQ-004 SHALL have parameter NUM_LAYERS, default 3, range 1..8, meaning layer count; index 0 is highest priority.
REQ-005 SHALL have parameter SCALE_SHIFT, default 1, range 0..2, meaning the fetch coordinate is the screen coordinate right-shifted by this amount.
REQ-006 SHALL have parameter LAYER_LAT, default 2, range 1..4, meaning the cycle delay from px_x/px_y to valid layer_rgb.
REQ-007 clkPixel  in  1  pixel clock; the block's only clock.
REQ-008 nreset  in  1  asynchronous, active-low reset.
REQ-009 layer_en  in  NUM_LAYERS  per-layer enable; sampled at frame start.
REQ-010 trans_key  in  8  RGB332 colour treated as transparent for every layer.
REQ-011 bg_color  in  8  RGB332 colour shown when every layer is transparent.
REQ-012 irq_line  in  12  line number that raises lineIrq.
REQ-013 layer_rgb  in  8*NUM_LAYERS  RGB332 per layer, layer i at bits [8i+7:8i].
REQ-014 px_x, px_y  out  12 each  scaled fetch coordinates.
REQ-015 px_valid  out  1  high while the fetch coordinate is inside the active area.
REQ-016 r_out, g_out, b_out  out  8 each  expanded output colour.
REQ-017 hsync, vsync  out  1 each  active-low sync pulses.
REQ-018 blank  out  1  high outside the active area.
REQ-019 frameDrawn  out  1  one-cycle pulse at the end of the active area.
REQ-020 lineIrq  out  1  one-cycle pulse at the start of line irq_line.

Function
REQ-021 h_count SHALL count 0..H_TOTAL-1 and wrap to 0; at each wrap, v_count SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-022 The active area SHALL be h_count<H_ACTIVE and v_count<V_ACTIVE; sync is asserted for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and v_count in the equivalent vertical window.
REQ-023 While active, px_x=h_count>>SCALE_SHIFT, px_y=v_count>>SCALE_SHIFT and px_valid=1; otherwise px_x, px_y and px_valid SHALL be 0.
REQ-024 hsync, vsync, blank, frameDrawn and lineIrq SHALL be delayed LAYER_LAT+1 cycles relative to the counters so they align with colour output.
REQ-025 Mixing rule: layer i is opaque when its shadowed enable bit is 1 and its colour is not trans_key; output is the opaque layer with the lowest index, or bg_color if no layer is opaque.
REQ-026 The mixed colour SHALL be registered, giving a total latency of LAYER_LAT+1 from coordinate to r_out/g_out/b_out.
REQ-027 Expansion: a channel field of 0 SHALL yield 0x00; any nonzero field SHALL be left-aligned with the low bits filled with 1s (r,g: field+5'b11111; b: field+6'b111111).
REQ-028 While the aligned blank is 1, r_out, g_out and b_out SHALL be 0.
REQ-029 The layer_en shadow register SHALL load at h_count=0, v_count=0 only, so a mid-frame change takes effect from the next frame.
REQ-030 frameDrawn SHALL pulse when h_count=0 and v_count=V_ACTIVE, once per frame.
REQ-031 lineIrq SHALL pulse when h_count=0 and v_count=irq_line; irq_line≥V_TOTAL SHALL never fire.
REQ-032 If irq_line=V_ACTIVE, frameDrawn and lineIrq SHALL pulse in the same cycle.

Reset
REQ-033 While nreset=0: counters=0, shadow enable=0, pipeline cleared, blank=1, hsync=vsync=1, colours=0, frameDrawn=lineIrq=0, px_*=0.
REQ-034 After reset is released mid-frame, the first cycle SHALL be h_count=0, v_count=0; no frameDrawn or lineIrq pulse SHALL occur until reached by counting.

Structure
REQ-035 A shared package fsx_pkg SHALL hold the default timing constants, the RGB332 field widths and the expansion function.
REQ-036 The timing counters and sync decode SHALL live in one sub-module, fsx_timing; fsx_compositor holds the mixer and alignment pipeline.

Verification
REQ-037 Reset test: set H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, then hold reset -> frame period is 14*7=98 cycles, hsync low for 2 cycles per line, frameDrawn exactly once per frame.
REQ-038 Priority test: layer_en=3'b111, layer_rgb={0x1C,0x03,0x00}, trans_key=0x00 -> output equals layer1=0x03 -> r=0,g=0,b=0xFF, 3 cycles after px_valid.
REQ-039 Transparency test: all layers 0x00, bg_color=0xE0 -> r=0xFF, g=0x00, b=0x00; during blank -> all 0.
REQ-040 Enable shadow test: clear layer_en[1] on line 2 -> layer1 still visible to frame end, masked from the next frame's first pixel.
REQ-041 IRQ test: irq_line=V_ACTIVE -> frameDrawn and lineIrq coincide; irq_line=4095 -> lineIrq never fires.
REQ-042 Scaling test: SCALE_SHIFT=1 -> px_x sequence is 0,0,1,1,2,2...; mid-line reset -> counters restart at 0,0 and blank=1.

Source files
------------

// File: rtl/fsx_pkg.sv
// Shared definitions for the FSX compositor: default raster timing,
// RGB332 field layout and the colour expansion helper.
package fsx_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned R_W   = 3;
    localparam int unsigned G_W   = 3;
    localparam int unsigned B_W   = 2;

    // A zero field stays black; otherwise the field is left-aligned and padded with ones.
    function automatic logic [23:0] expand332(input logic [7:0] c);
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        logic [7:0]     ro;
        logic [7:0]     go;
        logic [7:0]     bo;
        r  = c[7:5];
        g  = c[4:2];
        b  = c[1:0];
        ro = (r == '0) ? 8'h00 : {r, 5'b11111};
        go = (g == '0) ? 8'h00 : {g, 5'b11111};
        bo = (b == '0) ? 8'h00 : {b, 6'b111111};
        return {ro, go, bo};
    endfunction

endpackage

// File: rtl/fsx_timing.sv
// Raster counters plus the sync, active-area and event decode that
// the compositor delays to line up with its colour output.
module fsx_timing
    import fsx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] irq_line_i,
    output logic [CNT_W-1:0] h_count_o,
    output logic [CNT_W-1:0] v_count_o,
    output logic             active_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o,
    output logic             frame_start_o,
    output logic             frame_end_o,
    output logic             line_irq_o
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Out-of-range irq lines simply never compare equal to the vertical count.
    assign h_count_o     = h_q;
    assign v_count_o     = v_q;
    assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_n_o     = !((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_n_o     = !((v_q >= VS_START) && (v_q < VS_END));
    assign frame_start_o = (h_q == '0) && (v_q == '0);
    assign frame_end_o   = (h_q == '0) && (v_q == V_ACT);
    assign line_irq_o    = (h_q == '0) && (v_q == irq_line_i);

endmodule

// File: rtl/fsx_compositor.sv
// Priority layer mixer: picks the first opaque layer per pixel, expands
// RGB332 to 24-bit and delays sync/blank/events to match the colour path.
module fsx_compositor
    import fsx_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned NUM_LAYERS  = 3,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned LAYER_LAT   = 2
) (
    input  logic                    clkPixel,
    input  logic                    nreset,
    input  logic [NUM_LAYERS-1:0]   layer_en,
    input  logic [7:0]              trans_key,
    input  logic [7:0]              bg_color,
    input  logic [CNT_W-1:0]        irq_line,
    input  logic [8*NUM_LAYERS-1:0] layer_rgb,
    output logic [CNT_W-1:0]        px_x,
    output logic [CNT_W-1:0]        px_y,
    output logic                    px_valid,
    output logic [7:0]              r_out,
    output logic [7:0]              g_out,
    output logic [7:0]              b_out,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    blank,
    output logic                    frameDrawn,
    output logic                    lineIrq
);

    localparam int unsigned DLY = LAYER_LAT + 1;

    logic [CNT_W-1:0] h_count, v_count;
    logic             active, hsync_n, vsync_n, frame_start, frame_end, line_irq;

    fsx_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk_i         (clkPixel),
        .rst_ni        (nreset),
        .irq_line_i    (irq_line),
        .h_count_o     (h_count),
        .v_count_o     (v_count),
        .active_o      (active),
        .hsync_n_o     (hsync_n),
        .vsync_n_o     (vsync_n),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end),
        .line_irq_o    (line_irq)
    );

    // The counters idle at 0,0 during reset, so the fetch port is gated by reset to stay quiet.
    assign px_valid = active & nreset;
    assign px_x     = px_valid ? (h_count >> SCALE_SHIFT) : '0;
    assign px_y     = px_valid ? (v_count >> SCALE_SHIFT) : '0;

    logic [NUM_LAYERS-1:0] en_q;
    logic [7:0]            mix_q, mix_d;
    logic [DLY-1:0]        blank_q, hsync_q, vsync_q, frame_q, irq_q;

    always_comb begin
        mix_d = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (en_q[i] && (layer_rgb[8*i +: 8] != trans_key)) begin
                mix_d = layer_rgb[8*i +: 8];
            end
        end
    end

    // Enable shadow only reloads at the top-left pixel so a frame never mixes two enable sets.
    always_ff @(posedge clkPixel or negedge nreset) begin
        if (!nreset) begin
            en_q    <= '0;
            mix_q   <= '0;
            blank_q <= '1;
            hsync_q <= '1;
            vsync_q <= '1;
            frame_q <= '0;
            irq_q   <= '0;
        end else begin
            if (frame_start) begin
                en_q <= layer_en;
            end
            mix_q   <= mix_d;
            blank_q <= {blank_q[DLY-2:0], !active};
            hsync_q <= {hsync_q[DLY-2:0], hsync_n};
            vsync_q <= {vsync_q[DLY-2:0], vsync_n};
            frame_q <= {frame_q[DLY-2:0], frame_end};
            irq_q   <= {irq_q[DLY-2:0], line_irq};
        end
    end

    logic [23:0] rgb;
    assign rgb = expand332(mix_q);

    assign blank      = blank_q[DLY-1];
    assign hsync      = hsync_q[DLY-1];
    assign vsync      = vsync_q[DLY-1];
    assign frameDrawn = frame_q[DLY-1];
    assign lineIrq    = irq_q[DLY-1];
    assign r_out      = blank ? 8'h00 : rgb[23:16];
    assign g_out      = blank ? 8'h00 : rgb[15:8];
    assign b_out      = blank ? 8'h00 : rgb[7:0];

endmodule
